dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-master arbiter for the single-port data memory (dmem: async read, sync write, word-addressed by addr[17:2]).
- Master 0 is the mipse data port; master 1 is a secondary agent (DMA, debug loader or result-dump engine).
- Uses a registered round-robin grant with a bounded burst length, so neither master can starve the other.
- Sits between the masters and dmem and returns a per-master ack; the CPU stalls while m0_req=1 and m0_ack=0.

Parameters:
- DATA_W, 32, data and address width (matches `DATA_W).
- MEM_AW, 16, dmem word-address width; mem_a = mX_addr[MEM_AW+1:2].
- MAX_BURST, 4, maximum consecutive acked beats for one master while the other requests (>=1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  master 0 access request, level, held until ack.
- m0_we  in  1  master 0 write enable (valid with m0_req).
- m0_addr  in  DATA_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_rdata  out  DATA_W  master 0 read data.
- m0_ack  out  1  master 0 beat accepted this cycle.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1.
- mem_a  out  MEM_AW  dmem word address.
- mem_wd  out  DATA_W  dmem write data.
- mem_we  out  1  dmem write enable.
- mem_rd  in  DATA_W  dmem async read data.
- owner  out  2  current state (2'b00 IDLE, 2'b01 GNT0, 2'b10 GNT1), for debug/bench.

Behaviour:
- State machine with states IDLE, GNT0 and GNT1. Registered state: prio (1 bit, master preferred on tie) and bcnt (clog2(MAX_BURST+1) bits).
- Reset (rst=1 at posedge):
  - state=IDLE, prio=0, bcnt=0.
  - Outputs the same cycle the state is IDLE: all acks=0, mem_we=0, mem_a=0, mem_wd=0, rdata=0.
  - Reset mid-grant: the grant drops at that edge; no write is issued in the following cycle.
- IDLE:
  - Only one req set -> go to that GNTx.
  - Both set -> go to GNT[prio].
  - Neither set -> stay in IDLE.
  - bcnt<=0.
- GNTx:
  - mX_ack = mX_req (combinational).
  - mem_a, mem_wd and mem_we=mX_we&mX_req are driven from master X.
  - mX_rdata = mem_rd. The other master's rdata=0 and ack=0.
- Leaving GNTx (evaluated every cycle, other = 1-x):
  - mX_req and (bcnt<MAX_BURST-1 or !req_other) -> stay; bcnt<=bcnt+1, saturating at MAX_BURST-1.
  - Else if req_other -> GNTother, bcnt<=0, prio<=other.
  - Else -> IDLE, bcnt<=0, prio<=other.
- Latency:
  - A request raised in IDLE is acked in the next cycle (1-cycle arbitration bubble).
  - A handover between masters has no bubble.
- Beats:
  - One ack equals one completed beat.
  - A write commits at the posedge ending the ack cycle.
  - Read data is valid combinationally during the ack cycle.
- A master dropping req while granted gets no ack and is not counted. The grant moves on per the rules above.
- mem_we is never 1 unless exactly one ack is 1. The two acks are never both 1.
- Address bits [1:0] and bits above MEM_AW+1 are ignored. There is no alignment check.

Decomposition:
- Shared def.h additions:
  - State encodings ST_IDLE, ST_GNT0, ST_GNT1.
  - MEM_AW.
  - Reuse `DATA_W, `ENABLE and `DISABLE.
- One natural sub-module, rr_sel2: a combinational 2-way round-robin picker taking (req0, req1, prio) and returning (valid, winner). The FSM, burst counter and datapath muxes stay in dmem_arbiter.

Test Plan:
- Reset, then only m0 reads addr 0x8 for 3 cycles with dmem[2]=0xdeadbeef:
  - IDLE, then GNT0 the next cycle.
  - m0_ack=1 and m0_rdata=0xdeadbeef for 3 cycles.
  - m1_ack=0.
- Both masters request from IDLE after reset:
  - GNT0 first (prio=0).
  - With both held, m0 gets exactly 4 acks, then GNT1 with no bubble.
  - m1 gets 4 acks, then GNT0.
- m1 writes 0x12345678 to 0x7ffc while m0 is idle:
  - mem_we=1 and mem_a=0x1fff for one cycle.
  - dmem[0x1fff]=0x12345678 after the edge.
  - m0_rdata=0 throughout.
- m0 drops req mid-grant with m1 requesting: the next cycle is GNT1 with no idle cycle, and m0_ack=0 in the cycle m0_req=0.
- Assert rst during GNT1 with m1_we=1:
  - The next cycle shows IDLE, mem_we=0 and both acks=0.
  - The memory location is unchanged after that cycle.
  - The first grant after release with both requesting goes to m0.
- Random req/we on both masters for 5000 cycles:
  - Acks never overlap.
  - mem_we only with an ack.
  - No master waits more than MAX_BURST+1 cycles for an ack while requesting.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encodings and default widths for the dmem arbiter
package dmem_arbiter_pkg;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_MEM_AW = 16;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_e;
endpackage

// File: rtl/dmem_arbiter_rr_sel2.sv
// dmem_arbiter_rr_sel2: combinational two-way round-robin picker (prio wins ties)
module dmem_arbiter_rr_sel2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic valid,
  output logic winner
);
  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? prio : req1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: registered round-robin two-master arbiter with bounded bursts for single-port dmem
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MEM_AW    = DMEM_MEM_AW,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [MEM_AW-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [1:0]        owner
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);
  state_e state_q, state_d;
  logic prio_q, prio_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic g0, g1, cur_req, oth_req, stay, sel_valid, sel_win, unused_bits;
  assign g0      = state_q == ST_GNT0;
  assign g1      = state_q == ST_GNT1;
  assign cur_req = g1 ? m1_req : m0_req;
  assign oth_req = g1 ? m0_req : m1_req;
  assign stay    = cur_req & ((bcnt_q < BMAX) | ~oth_req);
  assign unused_bits = ^{m0_addr[1:0], m0_addr[DATA_W-1:MEM_AW+2],
                         m1_addr[1:0], m1_addr[DATA_W-1:MEM_AW+2]};
  dmem_arbiter_rr_sel2 u_sel (
    .req0  (m0_req),
    .req1  (m1_req),
    .prio  (prio_q),
    .valid (sel_valid),
    .winner(sel_win)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      bcnt_q  <= bcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    bcnt_d  = '0;
    if (!(g0 | g1)) begin
      state_d = sel_valid ? (sel_win ? ST_GNT1 : ST_GNT0) : ST_IDLE;
    end else if (stay) begin
      bcnt_d = (bcnt_q == BMAX) ? bcnt_q : bcnt_q + BW'(1);
    end else begin
      state_d = oth_req ? (g1 ? ST_GNT0 : ST_GNT1) : ST_IDLE;
      prio_d  = ~g1;
    end
  end
  always_comb begin
    m0_ack   = g0 & m0_req;
    m1_ack   = g1 & m1_req;
    m0_rdata = g0 ? mem_rd : '0;
    m1_rdata = g1 ? mem_rd : '0;
    mem_a    = g0 ? m0_addr[MEM_AW+1:2] : g1 ? m1_addr[MEM_AW+1:2] : '0;
    mem_wd   = g0 ? m0_wdata : g1 ? m1_wdata : '0;
    mem_we   = g0 ? (m0_we & m0_req) : (g1 & m1_we & m1_req);
    owner    = state_q;
  end
endmodule
